// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the wrap-around index helper used by the rotate-priority selector.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_GUARD     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority selector: returns the first set request at or
// after start_i, wrapping around the request vector.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_BITS-1:0] start_i,
  output logic               found_o,
  output logic [ID_BITS-1:0] idx_o
);

  logic [ID_BITS-1:0] cand_s;
  logic               hit_s;

  // Walk from the farthest offset to the nearest so the nearest hit overwrites
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand_s  = ID_BITS'(wrap_add(int'(start_i), int'(off), NUM_REQ));
      hit_s   = req_i[cand_s];
      found_o = found_o | hit_s;
      idx_o   = hit_s ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ requesters with message-level
// round-robin arbitration, a per-message lock and an idle-owner lock timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_BITS      = 2,
  parameter int TIMEOUT_BITS = 16,
  parameter int LOCK_TIMEOUT = 1000
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tx_enable_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_busy_i,
  output logic [ID_BITS-1:0]        grant_id_o,
  output logic                      locked_o,
  output logic                      timeout_pulse_o
);

  localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = TIMEOUT_BITS'(LOCK_TIMEOUT - 1);
  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX  = {TIMEOUT_BITS{1'b1}};
  localparam logic [ID_BITS-1:0]      LAST_ID  = ID_BITS'(NUM_REQ - 1);

  arb_state_e              state_q;
  logic [ID_BITS-1:0]      grant_q;
  logic [ID_BITS-1:0]      rr_ptr_q;
  logic                    locked_q;
  logic                    tx_enable_q;
  logic                    timeout_pulse_q;
  logic [BYTE_W-1:0]       tx_data_q;
  logic [TIMEOUT_BITS-1:0] idle_cnt_q;
  logic [TIMEOUT_BITS-1:0] idle_cnt_d;

  logic [NUM_REQ-1:0] cand_s;
  logic [ID_BITS-1:0] start_s;
  logic               pick_found_s;
  logic [ID_BITS-1:0] pick_idx_s;
  logic [ID_BITS-1:0] rr_next_s;
  logic [BYTE_W-1:0]  pick_data_s;
  logic               accept_s;
  logic               idle_tick_s;
  logic               timeout_hit_s;

  // While locked only the owner may compete, starting the search at the owner
  always_comb begin
    cand_s  = '0;
    start_s = rr_ptr_q;
    if (locked_q) begin
      cand_s[grant_q] = req_valid_i[grant_q];
      start_s         = grant_q;
    end else begin
      cand_s  = req_valid_i;
      start_s = rr_ptr_q;
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr_pick (
    .req_i   (cand_s),
    .start_i (start_s),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  assign accept_s    = rst_ni && (state_q == ST_IDLE) && !tx_busy_i && pick_found_s;
  assign idle_tick_s = (state_q == ST_IDLE) && locked_q && !tx_busy_i && !req_valid_i[grant_q];
  assign rr_next_s   = (pick_idx_s == LAST_ID) ? '0 : pick_idx_s + ID_BITS'(1);
  assign pick_data_s = req_data_i[BYTE_W*int'(pick_idx_s) +: BYTE_W];

  // Lock-idle counter: an accept always wins over a timeout in the same cycle
  always_comb begin
    idle_cnt_d    = idle_cnt_q;
    timeout_hit_s = 1'b0;
    if (accept_s) begin
      idle_cnt_d = '0;
    end else if (idle_tick_s) begin
      if (idle_cnt_q == CNT_LAST) begin
        idle_cnt_d    = '0;
        timeout_hit_s = 1'b1;
      end else if (idle_cnt_q != CNT_MAX) begin
        idle_cnt_d = idle_cnt_q + TIMEOUT_BITS'(1);
      end else begin
        idle_cnt_d = idle_cnt_q;
      end
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // Ready is the accept decision itself so the byte is consumed in this cycle
  always_comb begin
    req_ready_o = '0;
    if (accept_s) begin
      req_ready_o[pick_idx_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Arbiter FSM with all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      rr_ptr_q        <= '0;
      locked_q        <= 1'b0;
      tx_enable_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
      tx_data_q       <= '0;
      idle_cnt_q      <= '0;
    end else begin
      tx_enable_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
      idle_cnt_q      <= idle_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            tx_data_q   <= pick_data_s;
            grant_q     <= pick_idx_s;
            rr_ptr_q    <= rr_next_s;
            locked_q    <= !req_last_i[pick_idx_s];
            tx_enable_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end else if (timeout_hit_s) begin
            locked_q        <= 1'b0;
            timeout_pulse_q <= 1'b1;
            state_q         <= ST_IDLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE:     state_q <= ST_GUARD;
        // UART busy may lag dataAvailable by a cycle, so it is not sampled here
        ST_GUARD:     state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: state_q <= tx_busy_i ? ST_WAIT_DONE : ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_enable_o     = tx_enable_q;
  assign tx_data_o       = tx_data_q;
  assign grant_id_o      = grant_q;
  assign locked_o        = locked_q;
  assign timeout_pulse_o = timeout_pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester byte queues, a simple
// UART busy model and a scoreboard of expected {grant, byte, lock} per tx_enable.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int LOCKT = 10;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_enable;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          locked;
  logic          timeout_pulse;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .ID_BITS      (2),
    .TIMEOUT_BITS (16),
    .LOCK_TIMEOUT (LOCKT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .tx_enable_o     (tx_enable),
    .tx_data_o       (tx_data),
    .tx_busy_i       (tx_busy),
    .grant_id_o      (grant_id),
    .locked_o        (locked),
    .timeout_pulse_o (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       lock;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    logic [7:0] ord;
    int         n;
  } vec_t;

  exp_t       sb[$];
  logic [8:0] src_mem [NR][32];
  int         head [NR];
  int         tail [NR];
  int         acc_cyc [NR];
  logic [NR-1:0] rdy_seen;
  logic       prev_rdy;
  logic       prev_locked;
  logic       locked_before_pulse;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int frame_len = 3;
  int fall_cyc = 0;
  int pulse_cyc = 0;
  int pulse_cnt = 0;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [7:0] dat(input int v, input int i);
    return 8'(16 * v + i + 1);
  endfunction

  function automatic logic pending();
    logic p = 1'b0;
    for (int i = 0; i < NR; i++) p = p | (head[i] < tail[i]);
    return p;
  endfunction

  task automatic push_src(input int i, input logic [7:0] d, input logic l);
    src_mem[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d, input logic l);
    sb.push_back({id, d, l});
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
      acc_cyc[i] = -1;
    end
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    busy_cnt  = 0;
    rdy_seen  = '0;
    prev_rdy  = 1'b0;
    prev_locked = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic monitor();
    exp_t e;
    rdy_seen = req_ready;
    if (req_ready != '0) begin
      chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      for (int i = 0; i < NR; i++) if (req_ready[i]) acc_cyc[i] = cyc;
    end
    if (tx_enable || prev_rdy) chk("enable_latency", 32'(tx_enable), 32'(prev_rdy));
    if (tx_enable) begin
      busy_cnt = frame_len;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got byte %0h from %0d, none expected", tx_data, grant_id);
      end else begin
        e = sb.pop_front();
        chk("tx_grant", 32'(grant_id), 32'(e.id));
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("tx_locked", 32'(locked), 32'(e.lock));
      end
    end
    if (timeout_pulse) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      locked_before_pulse = prev_locked;
    end
    prev_rdy    = |req_ready;
    prev_locked = locked;
  endtask

  // Drive just after the rising edge, sample outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NR; i++) if (rdy_seen[i] && head[i] < tail[i]) head[i]++;
    if (busy_cnt > 0) begin
      tx_busy = 1'b1;
      busy_cnt--;
    end else begin
      if (tx_busy) fall_cyc = cyc;
      tx_busy = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][head[i]][7:0];
        req_last[i]        = src_mem[i][head[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_model();
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || pending() || busy_cnt != 0 || tx_busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", sb.size(), n);
    end
    repeat (3) step();
  endtask

  initial begin
    // id order packed with the first transmitted requester in bits [1:0]
    vecs[0] = '{1'b1, 4'b0010, {2'd0, 2'd0, 2'd0, 2'd1}, 1};
    vecs[1] = '{1'b1, 4'b1101, {2'd0, 2'd3, 2'd2, 2'd0}, 3};
    vecs[2] = '{1'b0, 4'b0100, {2'd0, 2'd0, 2'd0, 2'd2}, 1};
    vecs[3] = '{1'b0, 4'b1101, {2'd0, 2'd2, 2'd0, 2'd3}, 3};
    vecs[4] = '{1'b0, 4'b1111, {2'd2, 2'd1, 2'd0, 2'd3}, 4};
    vecs[5] = '{1'b0, 4'b0011, {2'd0, 2'd0, 2'd1, 2'd0}, 2};
    vecs[6] = '{1'b0, 4'b1010, {2'd0, 2'd0, 2'd1, 2'd3}, 2};

    rst_ni = 1'b0;
    clear_model();
    repeat (2) step();
    chk("reset_outputs", 32'({req_ready, tx_enable, tx_data, grant_id, locked, timeout_pulse}), 32'd0);
    rst_ni = 1'b1;

    // Table: single bytes with last=1, round-robin order across pointer values
    for (int v = 0; v < 7; v++) begin
      logic [1:0] id;
      if (vecs[v].rst) do_reset();
      for (int i = 0; i < NR; i++) if (vecs[v].mask[i]) push_src(i, dat(v, i), 1'b1);
      id = 2'd0;
      for (int j = 0; j < vecs[v].n; j++) begin
        id = vecs[v].ord[2*j +: 2];
        push_exp(id, dat(v, int'(id)), 1'b0);
      end
      drain(3000);
      chk("vec_grant", 32'(grant_id), 32'(id));
      chk("vec_locked", 32'(locked), 32'd0);
    end

    // Message lock: requester 0 sends A,B,C while requester 1 waits with 0x5A
    do_reset();
    push_src(0, 8'h41, 1'b0);
    push_src(0, 8'h42, 1'b0);
    push_src(0, 8'h43, 1'b1);
    push_src(1, 8'h5A, 1'b1);
    push_exp(2'd0, 8'h41, 1'b1);
    push_exp(2'd0, 8'h42, 1'b1);
    push_exp(2'd0, 8'h43, 1'b0);
    push_exp(2'd1, 8'h5A, 1'b0);
    drain(3000);

    // Long busy: the next accept must come one cycle after busy falls
    do_reset();
    frame_len = 200;
    push_src(3, 8'h77, 1'b1);
    push_exp(2'd3, 8'h77, 1'b0);
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    push_src(2, 8'h66, 1'b1);
    push_exp(2'd2, 8'h66, 1'b0);
    for (int n = 0; n < 400 && acc_cyc[2] < 0; n++) step();
    chk("busy_accept_gap", 32'(acc_cyc[2] - fall_cyc), 32'd1);
    drain(3000);
    frame_len = 3;

    // Lock timeout: owner 2 goes quiet mid-message, requester 3 is waiting
    do_reset();
    push_src(2, 8'h21, 1'b0);
    push_src(3, 8'h33, 1'b1);
    push_exp(2'd2, 8'h21, 1'b1);
    push_exp(2'd3, 8'h33, 1'b0);
    for (int n = 0; n < 100 && pulse_cnt == 0; n++) step();
    chk("timeout_fired", 32'(pulse_cnt), 32'd1);
    chk("timeout_delay", 32'(pulse_cyc - fall_cyc), 32'(LOCKT + 1));
    chk("locked_before_timeout", 32'(locked_before_pulse), 32'd1);
    chk("locked_after_timeout", 32'(locked), 32'd0);
    chk("served_at_timeout", 32'(acc_cyc[3]), 32'(pulse_cyc));
    drain(3000);
    chk("timeout_single_pulse", 32'(pulse_cnt), 32'd1);

    // Asynchronous reset while the frame is in flight
    do_reset();
    push_src(1, 8'h99, 1'b0);
    push_exp(2'd1, 8'h99, 1'b1);
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    repeat (2) step();
    chk("locked_before_reset", 32'(locked), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({req_ready, tx_enable, tx_data, grant_id, locked, timeout_pulse}), 32'd0);
    clear_model();
    repeat (2) step();
    rst_ni = 1'b1;
    push_src(2, 8'h55, 1'b1);
    push_exp(2'd2, 8'h55, 1'b0);
    drain(3000);
    chk("restart_grant", 32'(grant_id), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
